// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU issue stage and the combinational ALU it
// feeds.
//   alu_op_t      : 4-bit ALU operation code (ADD..AND, NDEF for undecodable)
//   OP_R / OP_I   : RV32I opcodes for register-register and register-immediate
//                   ALU instructions
//   F7_BASE/F7_SUB: funct7 values distinguishing ADD/SUB and legal shifts
// ---------------------------------------------------------------------------
package alu_pkg;

    typedef enum logic [3:0] {
        ADD  = 4'd0,
        SUB  = 4'd1,
        SLL  = 4'd2,
        SLT  = 4'd3,
        XOR  = 4'd4,
        SRL  = 4'd5,
        OR   = 4'd6,
        AND  = 4'd7,
        NDEF = 4'd8
    } alu_op_t;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

endpackage

// File: rtl/alu_issue_stage_regfile.sv
// ---------------------------------------------------------------------------
// alu_issue_stage_regfile
// Architectural register file for the issue stage.
//   clk_i, rst_i        : clock, synchronous active-high reset (clears all)
//   raddr1_i/rdata1_o   : asynchronous read port 1
//   raddr2_i/rdata2_o   : asynchronous read port 2
//   we_i/waddr_i/wdata_i: synchronous write port
// Register 0 reads as zero and ignores writes.
// ---------------------------------------------------------------------------
module alu_issue_stage_regfile #(
    parameter int DataSize = 32,
    parameter int RegCount = 32,
    parameter int AddrW    = $clog2(RegCount)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [AddrW-1:0]    raddr1_i,
    output logic [DataSize-1:0] rdata1_o,
    input  logic [AddrW-1:0]    raddr2_i,
    output logic [DataSize-1:0] rdata2_o,
    input  logic                we_i,
    input  logic [AddrW-1:0]    waddr_i,
    input  logic [DataSize-1:0] wdata_i
);

    logic [DataSize-1:0] regs_q [RegCount];

    // Storage: reset clears everything; writes to x0 are discarded so the
    // zero register never holds anything but zero.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < RegCount; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != '0)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    // Read ports are combinational; x0 is forced to zero at the port.
    assign rdata1_o = (raddr1_i == '0) ? '0 : regs_q[raddr1_i];
    assign rdata2_o = (raddr2_i == '0) ? '0 : regs_q[raddr2_i];

endmodule

// File: rtl/alu_issue_stage.sv
// ---------------------------------------------------------------------------
// alu_issue_stage
// Decode/issue stage in front of the combinational ALU.
//   clk, rst            : clock, synchronous active-high reset
//   instr_valid/instr   : incoming RV32I instruction (valid/ready handshake)
//   instr_ready         : stage accepts the instruction this cycle
//   ex_valid/ex_ready   : registered issue bundle handshake to execute side
//   src1, src2          : operands (rs1 value; rs2 value or immediate)
//   ALUType             : ALU operation code (NDEF for illegal)
//   ex_rd, ex_illegal   : destination register, illegal-instruction flag
//   wb_valid/wb_rd/wb_data : ALU result writeback into the register file
// A per-register busy scoreboard holds issue on RAW/WAW hazards until the
// matching writeback arrives; a same-cycle writeback is bypassed.
// ---------------------------------------------------------------------------
module alu_issue_stage #(
    parameter int DataSize  = 32,
    parameter int RegCount  = 32,
    parameter int ALUopSize = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 instr_valid,
    input  logic [31:0]          instr,
    output logic                 instr_ready,
    output logic                 ex_valid,
    input  logic                 ex_ready,
    output logic [DataSize-1:0]  src1,
    output logic [DataSize-1:0]  src2,
    output logic [ALUopSize-1:0] ALUType,
    output logic [4:0]           ex_rd,
    output logic                 ex_illegal,
    input  logic                 wb_valid,
    input  logic [4:0]           wb_rd,
    input  logic [DataSize-1:0]  wb_data
);

    import alu_pkg::*;

    logic [6:0] opcode;
    logic [6:0] funct7;
    logic [2:0] funct3;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       isRType;
    logic       isIType;
    alu_op_t    decOp;
    logic       decLegal;

    logic [DataSize-1:0] immValue;
    logic [DataSize-1:0] rfData1;
    logic [DataSize-1:0] rfData2;
    logic [DataSize-1:0] rs1Value;
    logic [DataSize-1:0] rs2Value;

    logic [RegCount-1:0] busy_q;
    logic [RegCount-1:0] busy_d;
    logic [RegCount-1:0] wbClearMask;
    logic [RegCount-1:0] busyEff;
    logic                stall;
    logic                accept;

    logic                exValid_q,   exValid_d;
    logic [DataSize-1:0] src1_q,      src1_d;
    logic [DataSize-1:0] src2_q,      src2_d;
    alu_op_t             aluType_q,   aluType_d;
    logic [4:0]          exRd_q,      exRd_d;
    logic                exIllegal_q, exIllegal_d;

    assign opcode  = instr[6:0];
    assign rd      = instr[11:7];
    assign funct3  = instr[14:12];
    assign rs1     = instr[19:15];
    assign rs2     = instr[24:20];
    assign funct7  = instr[31:25];
    assign isRType = (opcode == OP_R);
    assign isIType = (opcode == OP_I);

    // Instruction decode. I-type shares the R-type funct3 map except that
    // funct7 only matters for the shifts (there is no SUBI). funct3 011
    // (SLTU/SLTIU) is not supported by the ALU and stays NDEF.
    always_comb begin
        decOp = NDEF;
        if (isRType || isIType) begin
            case (funct3)
                3'b000: begin
                    if (isIType || (funct7 == F7_BASE)) begin
                        decOp = ADD;
                    end else if (funct7 == F7_SUB) begin
                        decOp = SUB;
                    end
                end
                3'b001: if (funct7 == F7_BASE) decOp = SLL;
                3'b010: if (isIType || (funct7 == F7_BASE)) decOp = SLT;
                3'b100: if (isIType || (funct7 == F7_BASE)) decOp = XOR;
                3'b101: if (funct7 == F7_BASE) decOp = SRL;
                3'b110: if (isIType || (funct7 == F7_BASE)) decOp = OR;
                3'b111: if (isIType || (funct7 == F7_BASE)) decOp = AND;
                default: decOp = NDEF;
            endcase
        end
    end

    assign decLegal = (decOp != NDEF);

    // Shift-immediates carry a 5-bit shamt; everything else uses the
    // sign-extended 12-bit immediate.
    always_comb begin
        if ((funct3 == 3'b001) || (funct3 == 3'b101)) begin
            immValue = {{(DataSize-5){1'b0}}, instr[24:20]};
        end else begin
            immValue = {{(DataSize-12){instr[31]}}, instr[31:20]};
        end
    end

    alu_issue_stage_regfile #(
        .DataSize (DataSize),
        .RegCount (RegCount),
        .AddrW    (5)
    ) u_regfile (
        .clk_i    (clk),
        .rst_i    (rst),
        .raddr1_i (rs1),
        .rdata1_o (rfData1),
        .raddr2_i (rs2),
        .rdata2_o (rfData2),
        .we_i     (wb_valid),
        .waddr_i  (wb_rd),
        .wdata_i  (wb_data)
    );

    // A writeback landing in the accept cycle is forwarded so the bundle sees
    // the value that the register file only holds after this edge.
    assign rs1Value = (wb_valid && (wb_rd == rs1) && (rs1 != '0)) ? wb_data : rfData1;
    assign rs2Value = (wb_valid && (wb_rd == rs2) && (rs2 != '0)) ? wb_data : rfData2;

    // Busy bits that the current writeback is about to clear no longer
    // block issue, which lets the dependent instruction go in the same cycle.
    always_comb begin
        wbClearMask = '0;
        if (wb_valid && (wb_rd != '0)) begin
            wbClearMask[wb_rd] = 1'b1;
        end
    end

    assign busyEff = busy_q & ~wbClearMask;

    // rs2 is only a register source for the register-register opcode.
    assign stall = busyEff[rs1] | (isRType & busyEff[rs2]) | busyEff[rd];

    assign instr_ready = !rst && !stall && (!exValid_q || ex_ready);
    assign accept      = instr_valid && instr_ready;

    // Scoreboard next state: clear on writeback, then set on a legal accept,
    // so a same-cycle set/clear of the same register leaves it busy.
    always_comb begin
        busy_d = busyEff;
        if (accept && decLegal && (rd != '0)) begin
            busy_d[rd] = 1'b1;
        end
    end

    // Issue bundle: load on accept, otherwise hold while execute stalls and
    // go empty once the held bundle is consumed.
    always_comb begin
        exValid_d   = exValid_q;
        src1_d      = src1_q;
        src2_d      = src2_q;
        aluType_d   = aluType_q;
        exRd_d      = exRd_q;
        exIllegal_d = exIllegal_q;
        if (accept) begin
            exValid_d   = 1'b1;
            src1_d      = rs1Value;
            src2_d      = isRType ? rs2Value : immValue;
            aluType_d   = decOp;
            exRd_d      = decLegal ? rd : 5'd0;
            exIllegal_d = !decLegal;
        end else if (ex_ready) begin
            exValid_d   = 1'b0;
        end
    end

    // State registers; reset drops any in-flight bundle and clears the
    // scoreboard regardless of same-cycle accepts or writebacks.
    always_ff @(posedge clk) begin
        if (rst) begin
            exValid_q   <= 1'b0;
            src1_q      <= '0;
            src2_q      <= '0;
            aluType_q   <= NDEF;
            exRd_q      <= 5'd0;
            exIllegal_q <= 1'b0;
            busy_q      <= '0;
        end else begin
            exValid_q   <= exValid_d;
            src1_q      <= src1_d;
            src2_q      <= src2_d;
            aluType_q   <= aluType_d;
            exRd_q      <= exRd_d;
            exIllegal_q <= exIllegal_d;
            busy_q      <= busy_d;
        end
    end

    assign ex_valid   = exValid_q;
    assign src1       = src1_q;
    assign src2       = src2_q;
    assign ALUType    = ALUopSize'(aluType_q);
    assign ex_rd      = exRd_q;
    assign ex_illegal = exIllegal_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// ---------------------------------------------------------------------------
// tb_alu_issue_stage
// Directed scenarios with hand-derived expectations, followed by a random
// phase compared against an instruction-level reference model (register and
// busy arrays updated per accepted instruction / writeback).
// ---------------------------------------------------------------------------
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_ready;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [3:0]  ALUType;
    logic [4:0]  ex_rd;
    logic        ex_illegal;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    logic [31:0] mReg [32];
    bit          mBusy [32];
    bit          mExValid;
    logic [31:0] mSrc1;
    logic [31:0] mSrc2;
    logic [3:0]  mOp;
    logic [4:0]  mRd;
    bit          mIll;

    always #5 clk = ~clk;

    alu_issue_stage dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .ex_valid    (ex_valid),
        .ex_ready    (ex_ready),
        .src1        (src1),
        .src2        (src2),
        .ALUType     (ALUType),
        .ex_rd       (ex_rd),
        .ex_illegal  (ex_illegal),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data)
    );

    // Operation for an instruction word from the ISA table; -1 when illegal.
    function automatic int refOp(input logic [31:0] w);
        int          baseOps [8];
        logic [6:0]  opc;
        logic [6:0]  f7;
        int          f3;
        baseOps = '{0, 2, 3, -1, 4, 5, 6, 7};
        opc = w[6:0];
        f7  = w[31:25];
        f3  = int'(w[14:12]);
        if (opc == 7'h33) begin
            if (f3 == 0 && f7 == 7'h20) return 1;
            if (f7 != 7'h00) return -1;
            return baseOps[f3];
        end
        if (opc == 7'h13) begin
            if ((f3 == 1 || f3 == 5) && f7 != 7'h00) return -1;
            return baseOps[f3];
        end
        return -1;
    endfunction

    function automatic logic [31:0] refImm(input logic [31:0] w);
        if (w[14:12] == 3'd1 || w[14:12] == 3'd5) return {27'd0, w[24:20]};
        return {{20{w[31]}}, w[31:20]};
    endfunction

    function automatic logic [31:0] refRead(input logic [4:0] r);
        if (r == 5'd0) return 32'd0;
        if (wb_valid && wb_rd == r) return wb_data;
        return mReg[r];
    endfunction

    function automatic bit refBusy(input logic [4:0] r);
        return (r != 5'd0) && mBusy[r] && !(wb_valid && wb_rd == r);
    endfunction

    function automatic bit refReady();
        bit hazard;
        if (rst) return 1'b0;
        hazard = refBusy(instr[19:15]) || refBusy(instr[11:7]) ||
                 ((instr[6:0] == 7'h33) && refBusy(instr[24:20]));
        return !hazard && (!mExValid || ex_ready);
    endfunction

    function automatic logic [31:0] encR(input int f7, input int r2, input int r1, input int f3, input int d);
        return (32'(f7) << 25) | (32'(r2) << 20) | (32'(r1) << 15) | (32'(f3) << 12) | (32'(d) << 7) | 32'h33;
    endfunction

    function automatic logic [31:0] encI(input int imm, input int r1, input int f3, input int d);
        return ((32'(imm) & 32'hFFF) << 20) | (32'(r1) << 15) | (32'(f3) << 12) | (32'(d) << 7) | 32'h13;
    endfunction

    // Advance the model by one instruction-level step using the inputs that
    // are present this cycle, then let the DUT take its clock edge.
    task automatic tick();
        bit          acc;
        int          op;
        logic [31:0] w;
        w = instr;
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                mReg[i]  = 32'd0;
                mBusy[i] = 1'b0;
            end
            mExValid = 1'b0; mSrc1 = 32'd0; mSrc2 = 32'd0; mOp = 4'd8; mRd = 5'd0; mIll = 1'b0;
        end else begin
            acc = instr_valid && refReady();
            op  = refOp(w);
            if (acc) begin
                mExValid = 1'b1;
                mSrc1    = refRead(w[19:15]);
                mSrc2    = (w[6:0] == 7'h33) ? refRead(w[24:20]) : refImm(w);
                mIll     = (op < 0);
                mOp      = mIll ? 4'd8 : 4'(op);
                mRd      = mIll ? 5'd0 : w[11:7];
            end else if (ex_ready) begin
                mExValid = 1'b0;
            end
            if (wb_valid && wb_rd != 5'd0) begin
                mReg[wb_rd]  = wb_data;
                mBusy[wb_rd] = 1'b0;
            end
            if (acc && op >= 0 && w[11:7] != 5'd0) mBusy[w[11:7]] = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input bit iv, input logic [31:0] w, input bit er,
                                 input bit wv, input logic [4:0] wr, input logic [31:0] wd);
        instr_valid = iv; instr = w; ex_ready = er;
        wb_valid = wv; wb_rd = wr; wb_data = wd;
        #2;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
        tick();
        tick();
        vectors++; if (instr_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_ready got %0b want 0", instr_ready); end
        vectors++; if (ex_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_ex_valid got %0b want 0", ex_valid); end
        vectors++; if (ALUType !== 4'd8) begin miscompares++; $display("[TB] FAIL reset_ALUType got %0d want 8", ALUType); end
        vectors++; if (src1 !== 32'd0 || src2 !== 32'd0) begin miscompares++; $display("[TB] FAIL reset_src got %h/%h want 0/0", src1, src2); end
        vectors++; if (ex_rd !== 5'd0 || ex_illegal !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_rd_ill got %0d/%0b want 0/0", ex_rd, ex_illegal); end
        rst = 1'b0;
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
        vectors++; if (instr_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL idle_ready got %0b want 1", instr_ready); end
    endtask

    task automatic test_addi();
        applyStimulus(1'b1, 32'h00500093, 1'b1, 1'b0, 5'd0, 32'd0);
        vectors++; if (instr_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL addi_ready got %0b want 1", instr_ready); end
        tick();
        vectors++; if (ex_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL addi_valid got %0b want 1", ex_valid); end
        vectors++; if (src1 !== 32'd0 || src2 !== 32'd5) begin miscompares++; $display("[TB] FAIL addi_src got %h/%h want 0/5", src1, src2); end
        vectors++; if (ALUType !== 4'd0 || ex_rd !== 5'd1) begin miscompares++; $display("[TB] FAIL addi_op_rd got %0d/%0d want 0/1", ALUType, ex_rd); end
    endtask

    task automatic test_bypass();
        applyStimulus(1'b1, 32'h002081B3, 1'b1, 1'b0, 5'd0, 32'd0);
        vectors++; if (instr_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL raw_stall got %0b want 0", instr_ready); end
        tick();
        vectors++; if (ex_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL drain_valid got %0b want 0", ex_valid); end
        applyStimulus(1'b1, 32'h002081B3, 1'b1, 1'b1, 5'd1, 32'd5);
        vectors++; if (instr_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL wb_release got %0b want 1", instr_ready); end
        tick();
        vectors++; if (src1 !== 32'd5 || src2 !== 32'd0) begin miscompares++; $display("[TB] FAIL bypass_src got %h/%h want 5/0", src1, src2); end
        vectors++; if (ALUType !== 4'd0 || ex_rd !== 5'd3) begin miscompares++; $display("[TB] FAIL bypass_op_rd got %0d/%0d want 0/3", ALUType, ex_rd); end
    endtask

    task automatic test_hold();
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 5'd1, 32'd9); tick();
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 5'd2, 32'd4); tick();
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 5'd3, 32'd0); tick();
        applyStimulus(1'b1, 32'h402081B3, 1'b0, 1'b0, 5'd0, 32'd0);
        vectors++; if (instr_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL sub_ready got %0b want 1", instr_ready); end
        tick();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 32'h00100213, 1'b0, 1'b0, 5'd0, 32'd0);
            vectors++; if (instr_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL hold_ready[%0d] got %0b want 0", i, instr_ready); end
            vectors++; if (ex_valid !== 1'b1 || src1 !== 32'd9 || src2 !== 32'd4 || ALUType !== 4'd1 || ex_rd !== 5'd3) begin
                miscompares++; $display("[TB] FAIL hold_bundle[%0d] got v=%0b %h/%h op=%0d rd=%0d want 1 9/4 op=1 rd=3", i, ex_valid, src1, src2, ALUType, ex_rd);
            end
            tick();
        end
        applyStimulus(1'b1, 32'h00100213, 1'b1, 1'b0, 5'd0, 32'd0);
        vectors++; if (instr_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL consume_ready got %0b want 1", instr_ready); end
        tick();
        vectors++; if (ex_valid !== 1'b1 || src2 !== 32'd1 || ALUType !== 4'd0 || ex_rd !== 5'd4) begin
            miscompares++; $display("[TB] FAIL b2b_bundle got v=%0b src2=%h op=%0d rd=%0d want 1 1 0 4", ex_valid, src2, ALUType, ex_rd);
        end
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 5'd3, 32'hA); tick();
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 5'd4, 32'hB); tick();
    endtask

    task automatic test_illegal();
        applyStimulus(1'b1, 32'h0020B1B3, 1'b1, 1'b0, 5'd0, 32'd0);
        tick();
        vectors++; if (ex_valid !== 1'b1 || ALUType !== 4'd8 || ex_illegal !== 1'b1 || ex_rd !== 5'd0) begin
            miscompares++; $display("[TB] FAIL sltu got v=%0b op=%0d ill=%0b rd=%0d want 1 8 1 0", ex_valid, ALUType, ex_illegal, ex_rd);
        end
        applyStimulus(1'b1, 32'h003182B3, 1'b1, 1'b0, 5'd0, 32'd0);
        vectors++; if (instr_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL illegal_no_busy got %0b want 1", instr_ready); end
        tick();
        vectors++; if (src1 !== 32'hA || src2 !== 32'hA || ex_illegal !== 1'b0 || ex_rd !== 5'd5) begin
            miscompares++; $display("[TB] FAIL add_x5 got %h/%h ill=%0b rd=%0d want a/a 0 5", src1, src2, ex_illegal, ex_rd);
        end
    endtask

    task automatic test_itype();
        applyStimulus(1'b1, 32'hFFF0C093, 1'b1, 1'b0, 5'd0, 32'd0);
        tick();
        vectors++; if (src1 !== 32'd9 || src2 !== 32'hFFFFFFFF || ALUType !== 4'd4 || ex_rd !== 5'd1) begin
            miscompares++; $display("[TB] FAIL xori got %h/%h op=%0d rd=%0d want 9/ffffffff 4 1", src1, src2, ALUType, ex_rd);
        end
        applyStimulus(1'b1, 32'h0030D093, 1'b1, 1'b1, 5'd1, 32'h12);
        vectors++; if (instr_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL srli_ready got %0b want 1", instr_ready); end
        tick();
        vectors++; if (src1 !== 32'h12 || src2 !== 32'd3 || ALUType !== 4'd5 || ex_rd !== 5'd1) begin
            miscompares++; $display("[TB] FAIL srli got %h/%h op=%0d rd=%0d want 12/3 5 1", src1, src2, ALUType, ex_rd);
        end
    endtask

    task automatic test_reset_inflight();
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 5'd5, 32'h77); tick();
        applyStimulus(1'b1, 32'h00128293, 1'b0, 1'b0, 5'd0, 32'd0);
        tick();
        vectors++; if (ex_valid !== 1'b1 || src1 !== 32'h77 || src2 !== 32'd1 || ex_rd !== 5'd5) begin
            miscompares++; $display("[TB] FAIL addi_x5 got v=%0b %h/%h rd=%0d want 1 77/1 5", ex_valid, src1, src2, ex_rd);
        end
        rst = 1'b1;
        applyStimulus(1'b1, 32'h00100213, 1'b0, 1'b1, 5'd6, 32'h55);
        tick();
        rst = 1'b0;
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
        vectors++; if (ex_valid !== 1'b0 || ALUType !== 4'd8) begin miscompares++; $display("[TB] FAIL rst_drop got v=%0b op=%0d want 0 8", ex_valid, ALUType); end
        applyStimulus(1'b1, 32'h005281B3, 1'b0, 1'b0, 5'd0, 32'd0);
        vectors++; if (instr_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL rst_busy_clear got %0b want 1", instr_ready); end
        tick();
        vectors++; if (ex_valid !== 1'b1 || src1 !== 32'd0 || src2 !== 32'd0 || ex_rd !== 5'd3) begin
            miscompares++; $display("[TB] FAIL rst_regs got v=%0b %h/%h rd=%0d want 1 0/0 3", ex_valid, src1, src2, ex_rd);
        end
    endtask

    function automatic logic [31:0] randInstr();
        int          kind;
        int          f3;
        int          legalF3 [7];
        int          d, a, b;
        legalF3 = '{0, 1, 2, 4, 5, 6, 7};
        kind = $urandom_range(0, 9);
        d = $urandom_range(0, 7); a = $urandom_range(0, 7); b = $urandom_range(0, 7);
        f3 = legalF3[$urandom_range(0, 6)];
        if (kind < 4) return encR((f3 == 0 && $urandom_range(0, 1) == 1) ? 32 : 0, b, a, f3, d);
        if (kind < 8) return encI((f3 == 1 || f3 == 5) ? $urandom_range(0, 31) : int'($urandom_range(0, 4095)), a, f3, d);
        case ($urandom_range(0, 3))
            0:       return encR(0, b, a, 3, d);
            1:       return encR(32, b, a, 5, d);
            2:       return encI($urandom_range(0, 4095), a, 3, d);
            default: return encI($urandom_range(0, 4095), a, 2, d) ^ 32'h10;
        endcase
    endfunction

    task automatic test_random();
        int          cands [$];
        logic [4:0]  wr;
        for (int n = 0; n < 600; n++) begin
            cands.delete();
            for (int i = 1; i < 32; i++) if (mBusy[i]) cands.push_back(i);
            if (cands.size() > 0 && $urandom_range(0, 3) != 0) wr = 5'(cands[$urandom_range(0, cands.size() - 1)]);
            else wr = 5'($urandom_range(0, 7));
            applyStimulus($urandom_range(0, 9) < 7, randInstr(), $urandom_range(0, 9) < 7,
                          $urandom_range(0, 9) < 4, wr, $urandom);
            vectors++; if (instr_ready !== refReady()) begin miscompares++; $display("[TB] FAIL rnd_ready[%0d] got %0b want %0b", n, instr_ready, refReady()); end
            tick();
            vectors++; if (ex_valid !== mExValid) begin miscompares++; $display("[TB] FAIL rnd_valid[%0d] got %0b want %0b", n, ex_valid, mExValid); end
            if (mExValid) begin
                vectors++; if (ALUType !== mOp || ex_rd !== mRd || ex_illegal !== mIll) begin
                    miscompares++; $display("[TB] FAIL rnd_ctrl[%0d] got op=%0d rd=%0d ill=%0b want op=%0d rd=%0d ill=%0b", n, ALUType, ex_rd, ex_illegal, mOp, mRd, mIll);
                end
                if (!mIll) begin
                    vectors++; if (src1 !== mSrc1 || src2 !== mSrc2) begin
                        miscompares++; $display("[TB] FAIL rnd_src[%0d] got %h/%h want %h/%h", n, src1, src2, mSrc1, mSrc2);
                    end
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        instr_valid = 1'b0; instr = 32'd0; ex_ready = 1'b0;
        wb_valid = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
        test_reset();
        test_addi();
        test_bypass();
        test_hold();
        test_illegal();
        test_itype();
        test_reset_inflight();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
